sar_search_4bit: RTL and testbench

SAR_SEARCH_4BIT -- requirements
Module: sar_search_4bit

---
 rtl/sar_pkg.sv | 13 +
 rtl/sar_search_4bit.sv | 134 +++++++++++++
 tb/tb_sar_search_4bit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sar_pkg.sv
// Shared constants for the successive-approximation search block:
// FSM state encoding and the default search width.
package sar_pkg;

  localparam int SAR_WIDTH_DEFAULT = 4;

  typedef logic [1:0] sar_state_t;

  localparam sar_state_t ST_IDLE   = 2'd0;
  localparam sar_state_t ST_SEARCH = 2'd1;
  localparam sar_state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/sar_search_4bit.sv
// Successive-approximation search against an external magnitude comparator.
// The block proposes a candidate on trial and reads back lt/gt/eq the same
// cycle, resolving one bit per clock from MSB to LSB. An equal compare exits
// early; a non-one-hot flag set aborts with error.
module sar_search_4bit
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             error
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONE = LSB_ONE << (WIDTH - 1);

  sar_state_t       state_reg, state_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [WIDTH-1:0] trial_reg, trial_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             found_reg, found_next;
  logic             error_reg, error_next;

  // Bit currently under test and the value accumulated once it is decided.
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] acc_without_k;
  logic [WIDTH-1:0] acc_decided;
  logic             flags_onehot;

  assign bit_k         = LSB_ONE << k_reg;
  assign acc_without_k = trial_reg & ~bit_k;
  assign acc_decided   = cmp_gt ? trial_reg : acc_without_k;
  assign flags_onehot  = (({1'b0, cmp_lt} + {1'b0, cmp_gt} + {1'b0, cmp_eq}) == 2'd1);

  // Next-state logic: accept start outside SEARCH, then one compare per cycle.
  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    trial_next  = trial_reg;
    result_next = result_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    found_next  = found_reg;
    error_next  = error_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next  = ST_SEARCH;
          k_next      = KW'(WIDTH - 1);
          trial_next  = MSB_ONE;
          result_next = '0;
          found_next  = 1'b0;
          error_next  = 1'b0;
          busy_next   = 1'b1;
        end else if (state_reg == ST_DONE) begin
          state_next = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (!flags_onehot) begin
          error_next  = 1'b1;
          result_next = acc_without_k;
          state_next  = ST_DONE;
          busy_next   = 1'b0;
          done_next   = 1'b1;
        end else if (cmp_eq) begin
          result_next = trial_reg;
          found_next  = 1'b1;
          state_next  = ST_DONE;
          busy_next   = 1'b0;
          done_next   = 1'b1;
        end else if (k_reg == '0) begin
          result_next = acc_decided;
          state_next  = ST_DONE;
          busy_next   = 1'b0;
          done_next   = 1'b1;
        end else begin
          // Next candidate: decided upper bits plus the next lower bit set.
          k_next     = k_reg - KW'(1);
          trial_next = acc_decided | (bit_k >> 1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset is asynchronous so it also aborts a search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      k_reg      <= '0;
      trial_reg  <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      found_reg  <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      k_reg      <= k_next;
      trial_reg  <= trial_next;
      result_reg <= result_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      found_reg  <= found_next;
      error_reg  <= error_next;
    end
  end

  assign trial  = trial_reg;
  assign result = result_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign found  = found_reg;
  assign error  = error_reg;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Bench for sar_search_4bit: a combinational comparator model closes the
// loop, and a plain binary-search reference predicts every trial and result.
module tb_sar_search_4bit;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] trial;
  logic         cmp_lt, cmp_gt, cmp_eq;
  logic         busy, done, found, error;
  logic [W-1:0] result;

  int           target;
  int           force_kind;  // 0 normal, 1 lt+gt both high, 2 no flag high
  int           n_checks;
  int           n_errors;

  sar_search_4bit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .trial  (trial),
    .cmp_lt (cmp_lt),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External magnitude comparator with fault injection.
  always_comb begin
    cmp_lt = (target < int'(trial));
    cmp_gt = (target > int'(trial));
    cmp_eq = (target == int'(trial));
    if (force_kind == 1) begin
      cmp_lt = 1'b1;
      cmp_gt = 1'b1;
      cmp_eq = 1'b0;
    end else if (force_kind == 2) begin
      cmp_lt = 1'b0;
      cmp_gt = 1'b0;
      cmp_eq = 1'b0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts at a falling edge with the DUT in IDLE or DONE. err_at is the
  // 1-based compare to corrupt (0 = none). poke drives start during the 2nd
  // compare. chain leaves the bench at the DONE cycle so the caller can restart.
  task automatic do_search(input int tgt, input int err_at, input int err_kind,
                           input bit poke, input bit chain);
    int trials[$];
    int acc, t, exp_res, last_trial;
    bit exp_found, exp_err;
    acc = 0; exp_res = 0; exp_found = 0; exp_err = 0;
    // Reference: textbook binary search from MSB, one candidate per bit.
    for (int k = W - 1; k >= 0; k--) begin
      t = acc + (1 << k);
      trials.push_back(t);
      if (err_at == trials.size()) begin
        exp_err = 1; exp_res = acc; break;
      end
      if (tgt == t) begin
        exp_found = 1; exp_res = t; break;
      end
      if (tgt > t) acc = t;
      if (k == 0) exp_res = acc;
    end

    target = tgt;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_result_clr", int'(result), 0);
    check("accept_found_clr", int'(found), 0);
    check("accept_error_clr", int'(error), 0);
    for (int i = 0; i < trials.size(); i++) begin
      check($sformatf("trial[%0d] tgt=%0d", i, tgt), int'(trial), trials[i]);
      check("busy_in_search", int'(busy), 1);
      check("done_in_search", int'(done), 0);
      if (err_at == i + 1) force_kind = err_kind;
      if (poke && i == 1) start = 1'b1;
      @(negedge clk);
      force_kind = 0;
      start = 1'b0;
    end
    last_trial = trials[trials.size() - 1];
    check("done_pulse", int'(done), 1);
    check("busy_in_done", int'(busy), 0);
    check($sformatf("result tgt=%0d err_at=%0d", tgt, err_at), int'(result), exp_res);
    check("found", int'(found), int'(exp_found));
    check("error", int'(error), int'(exp_err));
    $display("search tgt=%0d err_at=%0d poke=%0d chain=%0d -> result=%0d found=%0d error=%0d",
             tgt, err_at, poke, chain, result, found, error);
    if (!chain) begin
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      check("busy_idle", int'(busy), 0);
      check("trial_held", int'(trial), last_trial);
      check("result_held", int'(result), exp_res);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    target = 0; force_kind = 0; start = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_trial", int'(trial), 0);
    check("rst_result", int'(result), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_error", int'(error), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_search(11, 0, 0, 1'b0, 1'b0);   // trials 8,12,10,11
    do_search(8, 0, 0, 1'b0, 1'b0);    // eq on first compare
    do_search(0, 0, 0, 1'b0, 1'b0);    // trials 8,4,2,1, nothing found
    do_search(15, 0, 0, 1'b0, 1'b0);
    do_search(5, 0, 0, 1'b1, 1'b1);    // mid-search start ignored, restart in DONE
    do_search(7, 0, 0, 1'b0, 1'b0);
    do_search(13, 2, 1, 1'b0, 1'b0);   // lt+gt at 2nd compare after a gt -> 8
    do_search(3, 3, 2, 1'b0, 1'b0);    // no flag at 3rd compare

    // Reset during the 3rd SEARCH cycle.
    target = 11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_trial", int'(trial), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_found", int'(found), 0);
    check("midrst_error", int'(error), 0);
    $display("async reset mid-search -> trial=%0d busy=%0d", trial, busy);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_busy", int'(busy), 0);
    do_search(15, 0, 0, 1'b0, 1'b0);

    // Randomized searches with occasional faults, pokes and back-to-back starts.
    for (int n = 0; n < 40; n++) begin
      int tgt, ea, ek;
      bit pk, ch;
      tgt = int'($urandom_range(0, 15));
      ea  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      ek  = int'($urandom_range(1, 2));
      pk  = 1'($urandom_range(0, 1));
      ch  = 1'($urandom_range(0, 1));
      do_search(tgt, ea, ek, pk, ch);
    end
    @(negedge clk);
    @(negedge clk);
    check("final_idle_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
